fft_frame_sequencer: RTL and testbench

//  Sequences the shared FFT butterfly datapath inside FAS. Captures the FIR output stream into a

---
 rtl/fft_frame_sequencer.sv | 163 ++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: captures the FIR sample stream into two ping-pong
// frame banks and steps the shared butterfly datapath through NSTAGE
// stages per full bank, pulsing fft_valid per frame and raising done
// after FRAMES frames.
// Optional build macro: FAS_SEQ_TIMEOUT_EN adds a per-stage watchdog that
// abandons a stalled frame and sets the sticky err flag.
module fft_frame_sequencer #(
  parameter int DW     = 16,
  parameter int NPT    = 16,
  parameter int NSTAGE = 4,
  parameter int FRAMES = 64
`ifdef FAS_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic [NPT*DW-1:0] frame_data,
  output logic              stage_en,
  output logic [1:0]        stage_sel,
  input  logic              stage_done,
  output logic              fft_valid,
  output logic [6:0]        frame_cnt,
  output logic              done,
  output logic              overrun,
  output logic              err
);

  localparam int PW = $clog2(NPT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT} state_t;

  state_t          state;
  logic [DW-1:0]   mem [2][NPT];
  logic [1:0]      full;
  logic            wr_bank;
  logic            rd_bank;
  logic [PW-1:0]   wr_ptr;
  logic            accept;
  logic            drop;
  logic            release_bank;
  logic [NPT*DW-1:0] rd_frame;

  // Capture is frozen once the run is complete; a full write bank means both banks are full.
  assign accept = in_valid && !done && !full[wr_bank];
  assign drop   = in_valid && !done &&  full[wr_bank];

`ifdef FAS_SEQ_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       timeout;

  assign timeout      = (state == S_WAIT) && !stage_done && (wd_cnt == 8'(TIMEOUT - 1));
  assign release_bank = (state == S_EMIT) || timeout;
`else
  assign release_bank = (state == S_EMIT);
  assign err          = 1'b0;
`endif

  // Flatten the oldest bank, sample 0 in the LSBs.
  for (genvar g = 0; g < NPT; g++) begin : g_pack
    assign rd_frame[g*DW +: DW] = mem[rd_bank][g];
  end

  // Sample storage; contents need no reset since full flags gate their use.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_bank][wr_ptr] <= in_data;
  end

  // Bank bookkeeping: fill pointer, full flags, fill/process order, overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      // Release and fill always target different banks, so both may land together.
      if (release_bank) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (accept) begin
        if (wr_ptr == PW'(NPT - 1)) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_ptr        <= '0;
        end else begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if (drop) overrun <= 1'b1;
    end
  end

  // Stage sequencer with registered outputs; stage_sel doubles as the stage counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      stage_en   <= 1'b0;
      stage_sel  <= '0;
      fft_valid  <= 1'b0;
      frame_cnt  <= '0;
      done       <= 1'b0;
      frame_data <= '0;
`ifdef FAS_SEQ_TIMEOUT_EN
      err        <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      stage_en  <= 1'b0;
      fft_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (full[rd_bank] && !done) begin
            frame_data <= rd_frame;
            stage_sel  <= '0;
            stage_en   <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef FAS_SEQ_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (stage_done) begin
            if (stage_sel == 2'(NSTAGE - 1)) begin
              fft_valid <= 1'b1;
              state     <= S_EMIT;
            end else begin
              stage_sel <= stage_sel + 2'd1;
              stage_en  <= 1'b1;
              state     <= S_ISSUE;
            end
          end
`ifdef FAS_SEQ_TIMEOUT_EN
          else if (timeout) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
`endif
        end
        S_EMIT: begin
          if (frame_cnt != 7'(FRAMES)) begin
            frame_cnt <= frame_cnt + 7'd1;
            if (frame_cnt == 7'(FRAMES - 1)) done <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Testbench for fft_frame_sequencer: directed scenarios with a frame-queue
// reference model checked every cycle, plus literal expectations.
`timescale 1ns/1ps
module tb_fft_frame_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [15:0]  in_data = '0;
  logic         stage_done = 1'b0;
  logic [255:0] frame_data;
  logic         stage_en;
  logic [1:0]   stage_sel;
  logic         fft_valid;
  logic [6:0]   frame_cnt;
  logic         done;
  logic         overrun;
  logic         err;

  fft_frame_sequencer #(
    .DW(16), .NPT(16), .NSTAGE(4), .FRAMES(64)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .frame_data(frame_data), .stage_en(stage_en), .stage_sel(stage_sel),
    .stage_done(stage_done), .fft_valid(fft_valid), .frame_cnt(frame_cnt),
    .done(done), .overrun(overrun), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: frames as a queue ----------------
  logic [255:0] q[$];
  logic [255:0] cur;
  logic [255:0] fd_exp;
  int  cur_n, m_cnt, en_at, fv_at, m_sel, wcnt, fd_start, fd_until;
  bit  m_live = 0, m_busy, m_wait, m_ov, m_done, m_err, fd_on, start_now, tmo_now;
  int  cyc = 0;

  // monitor records
  int fv_seen, en_seen, first_en_cyc, last_sd_cyc, fv_cyc, last_in_cyc;
  int sel_log[$];
  logic [255:0] fd_at_fv;

  // responder configuration
  int rsp_delay = 0;
  bit kick = 0;
  bit spur_issue = 0;
  int cd = 0;

  always @(negedge clk) begin
    cyc++;
    if (m_live) begin
      chk("stage_en", stage_en, cyc == en_at);
      chk("fft_valid", fft_valid, cyc == fv_at);
      chk("frame_cnt", frame_cnt, m_cnt);
      chk("done", done, m_done);
      chk("overrun", overrun, m_ov);
      chk("err", err, m_err);
      if (cyc == en_at || m_wait) chk("stage_sel", stage_sel, m_sel);
      if (fd_on && cyc >= fd_start && (m_busy || cyc <= fd_until)) chk("frame_data", frame_data, fd_exp);
    end
    if (stage_en === 1'b1) begin
      en_seen++;
      sel_log.push_back(int'(stage_sel));
      if (first_en_cyc < 0) first_en_cyc = cyc;
    end
    if (fft_valid === 1'b1) begin
      fv_seen++;
      fv_cyc = cyc;
      fd_at_fv = frame_data;
    end
    if (stage_done) last_sd_cyc = cyc;
    if (in_valid) last_in_cyc = cyc;

    if (rst) begin
      q.delete(); cur = '0; cur_n = 0;
      m_busy = 0; m_wait = 0; m_ov = 0; m_done = 0; m_err = 0;
      m_cnt = 0; en_at = -1; fv_at = -1; m_sel = 0; wcnt = 0;
      fd_on = 0; fd_start = 0; fd_until = -1; m_live = 1;
    end else if (m_live) begin
      start_now = !m_busy && q.size() > 0 && !m_done;
      tmo_now = 0;
      if (m_wait) begin
        if (stage_done) begin
          m_wait = 0; wcnt = 0;
          if (m_sel == 3) fv_at = cyc + 1;
          else begin m_sel++; en_at = cyc + 1; end
        end else begin
          wcnt++;
`ifdef FAS_SEQ_TIMEOUT_EN
          if (wcnt == 255) begin m_wait = 0; wcnt = 0; m_err = 1; tmo_now = 1; end
`endif
        end
      end
      if (cyc == en_at) m_wait = 1;
      if (in_valid && !m_done) begin
        if (q.size() < 2) begin
          cur[cur_n*16 +: 16] = in_data;
          cur_n++;
          if (cur_n == 16) begin q.push_back(cur); cur = '0; cur_n = 0; end
        end else m_ov = 1;
      end
      if (cyc == fv_at) begin
        void'(q.pop_front());
        m_busy = 0; fd_until = cyc + 1;
        if (m_cnt < 64) m_cnt++;
        if (m_cnt == 64) m_done = 1;
      end
      if (tmo_now) begin
        void'(q.pop_front());
        m_busy = 0; fd_until = cyc;
      end
      if (start_now) begin
        m_busy = 1; m_sel = 0; en_at = cyc + 1;
        fd_exp = q[0]; fd_on = 1; fd_start = cyc + 1;
      end
    end
  end

  // Butterfly datapath stand-in: stage_done rsp_delay cycles after stage_en.
  always @(posedge clk) begin
    #1;
    if (rsp_delay > 0 || kick || spur_issue || cd > 0) begin
      stage_done = 1'b0;
      if (kick) begin stage_done = 1'b1; kick = 0; end
      if (cd > 0) begin cd--; if (cd == 0) stage_done = 1'b1; end
      if (stage_en === 1'b1) begin
        if (spur_issue) stage_done = 1'b1;
        if (rsp_delay > 0) cd = rsp_delay;
      end
    end else begin
      stage_done = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic cfg(input int dly, input bit k, input bit spur);
    #2;
    rsp_delay = dly; kick = k; spur_issue = spur;
  endtask

  task automatic clr_mon();
    fv_seen = 0; en_seen = 0; sel_log.delete();
    first_en_cyc = -1; last_sd_cyc = -1; fv_cyc = -1; last_in_cyc = -1;
  endtask

  task automatic wait_fv(input int target, input int budget, input string name);
    int n = 0;
    while (fv_seen < target && n < budget) begin tick(); n++; end
    chk({name, " fft_valid count"}, fv_seen, target);
  endtask

  task automatic chk_sel_seq(input string name);
    chk({name, " stage_en count"}, sel_log.size(), 4);
    for (int k = 0; k < sel_log.size() && k < 4; k++) chk({name, " stage_sel order"}, sel_log[k], k);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clr_mon();
    // 1: reset
    do_reset();
    chk("rst stage_en", stage_en, 0);
    chk("rst stage_sel", stage_sel, 0);
    chk("rst fft_valid", fft_valid, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    chk("rst done", done, 0);
    chk("rst overrun", overrun, 0);
    chk("rst err", err, 0);
    chk("rst frame_data", frame_data, 0);
    clr_mon();
    idle(5);
    chk("idle no stage_en", en_seen, 0);

    // 2: single frame, stage_done 3 cycles after stage_en
    cfg(3, 0, 0);
    clr_mon();
    for (int i = 1; i <= 16; i++) send(16'(i));
    wait_fv(1, 100, "single");
    chk("single low word", fd_at_fv[15:0], 16'h0001);
    chk("single top word", fd_at_fv[255:240], 16'h0010);
    chk_sel_seq("single");
    chk("full->stage_en latency", first_en_cyc - last_in_cyc, 2);
    chk("stage_done->fft_valid latency", fv_cyc - last_sd_cyc, 1);
    idle(3);
    chk("single frame_cnt", frame_cnt, 1);
    chk("single fft_valid pulses", fv_seen, 1);

    // 3: back-to-back stream of 1024 samples
    do_reset();
    cfg(1, 0, 0);
    clr_mon();
    for (int i = 0; i < 1024; i++) send(16'(i * 37 + 5));
    wait_fv(64, 200, "stream");
    idle(3);
    chk("stream frame_cnt", frame_cnt, 64);
    chk("stream done", done, 1);
    chk("stream overrun", overrun, 0);
    chk("stream stage_en count", en_seen, 256);
    send(16'hBEEF);
    idle(20);
    chk("post-done overrun", overrun, 0);
    chk("post-done frame_cnt", frame_cnt, 64);
    chk("post-done fft_valid", fv_seen, 64);

    // 4: overrun with stage_done held low
    do_reset();
    cfg(0, 0, 0);
    clr_mon();
    for (int i = 1; i <= 32; i++) send(16'(i));
    idle(1);
    chk("overrun before 33", overrun, 0);
    send(16'd33);
    chk("overrun on 33", overrun, 1);
    chk("held bank low word", frame_data[15:0], 16'h0001);
    chk("held bank top word", frame_data[255:240], 16'h0010);
    cfg(1, 1, 0);
    wait_fv(2, 200, "overrun drain");
    chk("second bank low word", fd_at_fv[15:0], 16'h0011);
    chk("second bank top word", fd_at_fv[255:240], 16'h0020);
    idle(3);
    chk("overrun drain frame_cnt", frame_cnt, 2);
    chk("overrun sticky", overrun, 1);

    // 5: spurious stage_done in IDLE and in ISSUE
    do_reset();
    cfg(0, 0, 0);
    clr_mon();
    cfg(0, 1, 0);
    idle(4);
    chk("idle spurious stage_en", en_seen, 0);
    chk("idle spurious stage_sel", stage_sel, 0);
    cfg(0, 0, 1);
    for (int i = 1; i <= 16; i++) send(16'(16'h0050 + i));
    idle(20);
    chk("issue spurious stage_en count", en_seen, 1);
    chk("issue spurious stage_sel", stage_sel, 0);
    chk("issue spurious fft_valid", fv_seen, 0);
    cfg(1, 1, 0);
    wait_fv(1, 100, "spurious resume");
    chk_sel_seq("spurious resume");
    chk("spurious resume low word", fd_at_fv[15:0], 16'h0051);

`ifdef FAS_SEQ_TIMEOUT_EN
    // 6: stalled stage trips the watchdog
    do_reset();
    cfg(0, 0, 0);
    clr_mon();
    for (int i = 1; i <= 16; i++) send(16'(i));
    idle(300);
    chk("stall err", err, 1);
    chk("stall fft_valid", fv_seen, 0);
    chk("stall frame_cnt", frame_cnt, 0);
    cfg(1, 0, 0);
    for (int i = 1; i <= 16; i++) send(16'(16'h0100 + i));
    wait_fv(1, 100, "after stall");
    chk("after stall low word", fd_at_fv[15:0], 16'h0101);
    idle(3);
    chk("after stall frame_cnt", frame_cnt, 1);
    chk("after stall err sticky", err, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
